shake_xof_reader: RTL and testbench

// - Squeeze-side consumer for shake128_top. Takes a byte-length request and reads 128-bit
//   XOF words from the core via its o_valid/i_ack handshake.
// - Emits the bytes downstream as a 64-bit valid/ready stream with byte-keep and last.
// - Feeds samplers (rejection/CBD) that need an arbitrary number of XOF bytes.

---
 rtl/shake_pkg.sv | 25 ++
 rtl/shake_xof_reader_if.sv | 30 +++
 rtl/shake_xof_reader.sv | 113 +++++++++++
 tb/tb_shake_xof_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// Shared types and helpers for the SHAKE squeeze-side reader.
package shake_pkg;

    localparam int unsigned XOF_W  = 128;
    localparam int unsigned OUT_W  = 64;
    localparam int unsigned KEEP_W = OUT_W / 8;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StEmitLo,
        StEmitHi,
        StAck,
        StGap
    } state_e;

    // Contiguous byte mask for the bytes still owed, capped at a full output word.
    function automatic logic [KEEP_W-1:0] keep_from_rem(input int unsigned rem);
        if (rem >= KEEP_W) begin
            return '1;
        end
        return KEEP_W'((32'd1 << rem) - 32'd1);
    endfunction

endpackage

// File: rtl/shake_xof_reader_if.sv
// Request, core-squeeze and output-stream signals of the XOF reader.
interface shake_xof_reader_if #(
    parameter int unsigned LEN_W = 16
);
    import shake_pkg::*;

    logic                 i_req_valid;
    logic [LEN_W-1:0]     i_req_len;
    logic                 o_req_ready;
    logic [XOF_W-1:0]     i_xof_data;
    logic                 i_xof_valid;
    logic                 o_xof_ack;
    logic [OUT_W-1:0]     o_data;
    logic [KEEP_W-1:0]    o_keep;
    logic                 o_valid;
    logic                 o_last;
    logic                 i_ready;
    logic                 o_busy;

    modport slave (
        input  i_req_valid, i_req_len, i_xof_data, i_xof_valid, i_ready,
        output o_req_ready, o_xof_ack, o_data, o_keep, o_valid, o_last, o_busy
    );

    modport master (
        output i_req_valid, i_req_len, i_xof_data, i_xof_valid, i_ready,
        input  o_req_ready, o_xof_ack, o_data, o_keep, o_valid, o_last, o_busy
    );

endinterface

// File: rtl/shake_xof_reader.sv
// Pulls 128-bit XOF words from the SHAKE core and re-emits the requested number of
// bytes as a 64-bit valid/ready stream with keep and last.
module shake_xof_reader
    import shake_pkg::*;
#(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned ACK_GAP = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    shake_xof_reader_if.slave bus
);

    localparam int unsigned GapW = (ACK_GAP > 1) ? $clog2(ACK_GAP) : 1;

    state_e            state_q, state_d;
    logic [XOF_W-1:0]  hold_q, hold_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [GapW-1:0]   gap_q, gap_d;

    logic              emit;
    logic              fire;
    logic              is_last;
    logic [LEN_W-1:0]  take;
    logic [OUT_W-1:0]  half;
    state_e            after_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rem_d   = rem_q;
        gap_d   = gap_q;

        emit       = (state_q == StEmitLo) || (state_q == StEmitHi);
        fire       = emit && bus.i_ready;
        is_last    = rem_q <= LEN_W'(KEEP_W);
        // Min-clamped step so rem never wraps.
        take       = is_last ? rem_q : LEN_W'(KEEP_W);
        half       = (state_q == StEmitHi) ? hold_q[XOF_W-1:OUT_W] : hold_q[OUT_W-1:0];
        after_word = (rem_q != '0) ? StFetch : StIdle;

        bus.o_req_ready = (state_q == StIdle);
        bus.o_busy      = (state_q != StIdle);
        bus.o_xof_ack   = (state_q == StAck);
        bus.o_valid     = emit;
        bus.o_data      = emit ? half : '0;
        bus.o_keep      = emit ? keep_from_rem(32'(rem_q)) : '0;
        bus.o_last      = emit && is_last;

        unique case (state_q)
            StIdle: begin
                if (bus.i_req_valid) begin
                    rem_d = bus.i_req_len;
                    if (bus.i_req_len != '0) begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (bus.i_xof_valid) begin
                    hold_d  = bus.i_xof_data;
                    state_d = StEmitLo;
                end
            end
            StEmitLo: begin
                if (fire) begin
                    rem_d   = rem_q - take;
                    state_d = is_last ? StAck : StEmitHi;
                end
            end
            StEmitHi: begin
                if (fire) begin
                    rem_d   = rem_q - take;
                    state_d = StAck;
                end
            end
            StAck: begin
                // Unused bytes of a partial word are dropped here with the ack.
                if (ACK_GAP > 0) begin
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    state_d = after_word;
                end
            end
            StGap: begin
                if (gap_q == GapW'(ACK_GAP - 1)) begin
                    state_d = after_word;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_shake_xof_reader.sv
// Self-checking bench for shake_xof_reader with a behavioural squeeze core and a beat scoreboard.
module tb_shake_xof_reader;
    import shake_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic clk;
    logic rst_n;

    shake_xof_reader_if #(.LEN_W(16)) bus ();

    shake_xof_reader #(.LEN_W(16), .ACK_GAP(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t sb[$];
    int    exp_pos;
    int    exp_acks;
    int    ack_cnt;
    int    beats_seen;
    int    ready_mode;
    int    ready_limit;
    logic  core_restart;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // First two words are the SHAKE128 squeeze of the reference message; the rest are synthetic.
    function automatic logic [127:0] core_word(input int idx);
        logic [31:0] s;
        if (idx == 0) return {64'hb3c3bb0b4a91f811, 64'hf56f3eef13fcaf57};
        if (idx == 1) return {64'h953e262071b7c411, 64'h51cea816661744cb};
        s = 32'hC0DE0000 | 32'(idx);
        return {s ^ 32'h33333333, s ^ 32'h22222222, s ^ 32'h11111111, s};
    endfunction

    // Behavioural core: valid stays up with the old word through the ack and one cycle after,
    // then the word advances and valid drops for two refresh cycles.
    int   core_pos;
    logic core_stale;
    int   core_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || core_restart) begin
            core_pos   <= 0;
            core_stale <= 1'b0;
            core_wait  <= 0;
        end else begin
            if (core_wait > 0) core_wait <= core_wait - 1;
            if (bus.o_xof_ack) begin
                core_stale <= 1'b1;
            end else if (core_stale) begin
                core_stale <= 1'b0;
                core_pos   <= core_pos + 1;
                core_wait  <= 2;
            end
        end
    end

    assign bus.i_xof_valid = (core_wait == 0);
    assign bus.i_xof_data  = (core_wait == 0) ? core_word(core_pos) : {4{32'hBAD0BAD0}};

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       bus.i_ready = 1'($urandom_range(0, 1));
            3:       bus.i_ready = (beats_seen < ready_limit);
            default: bus.i_ready = 1'b1;
        endcase
    end

    logic        held;
    logic [63:0] held_data;
    logic [7:0]  held_keep;
    logic        held_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (bus.o_xof_ack) ack_cnt++;
            if (held) begin
                check_eq("stall_valid", 64'(bus.o_valid), 64'd1);
                check_eq("stall_data", bus.o_data, held_data);
                check_eq("stall_keep", 64'(bus.o_keep), 64'(held_keep));
                check_eq("stall_last", 64'(bus.o_last), 64'(held_last));
            end
            if (bus.o_valid && bus.i_ready) begin
                beats_seen++;
                if (sb.size() == 0) begin
                    check_eq("unexpected_beat", 64'(sb.size()), 64'd1);
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    check_eq("beat_data", bus.o_data, b.data);
                    check_eq("beat_keep", 64'(bus.o_keep), 64'(b.keep));
                    check_eq("beat_last", 64'(bus.o_last), 64'(b.last));
                end
            end
            held      = bus.o_valid && !bus.i_ready;
            held_data = bus.o_data;
            held_keep = bus.o_keep;
            held_last = bus.o_last;
        end
    end

    task automatic push_req(input int len);
        int rem;
        logic [127:0] w;
        beat_t b;
        rem = len;
        while (rem > 0) begin
            w = core_word(exp_pos);
            for (int h = 0; h < 2; h++) begin
                if (rem > 0) begin
                    b.data = (h == 0) ? w[63:0] : w[127:64];
                    b.keep = (rem >= 8) ? 8'hFF : 8'(8'hFF >> (8 - rem));
                    b.last = (rem <= 8);
                    sb.push_back(b);
                    rem = (rem >= 8) ? rem - 8 : 0;
                end
            end
            exp_pos++;
            exp_acks++;
        end
    endtask

    task automatic drive_req(input int len);
        bus.i_req_valid = 1'b1;
        bus.i_req_len   = 16'(len);
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
    endtask

    task automatic do_req(input int len, input int mode, input string tag);
        int cyc;
        ready_mode = mode;
        ack_cnt    = 0;
        exp_acks   = 0;
        beats_seen = 0;
        push_req(len);
        drive_req(len);
        cyc = 0;
        while (!(sb.size() == 0 && bus.o_req_ready) && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, "_done"}, 64'(cyc < 4000), 64'd1);
        check_eq({tag, "_acks"}, 64'(ack_cnt), 64'(exp_acks));
        check_eq({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
        sb.delete();
    endtask

    task automatic restart_core();
        core_restart = 1'b1;
        @(posedge clk);
        #1;
        core_restart = 1'b0;
        exp_pos = 0;
    endtask

    initial begin
        int bad_ready;
        int seen_valid;
        int cyc;

        rst_n           = 1'b0;
        bus.i_req_valid = 1'b0;
        bus.i_req_len   = '0;
        bus.i_ready     = 1'b1;
        ready_mode      = 0;
        ready_limit     = 0;
        core_restart    = 1'b0;
        exp_pos         = 0;
        ack_cnt         = 0;
        beats_seen      = 0;
        held            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 64'(bus.o_req_ready), 64'd1);
        check_eq("rst_valid", 64'(bus.o_valid), 64'd0);
        check_eq("rst_ack", 64'(bus.o_xof_ack), 64'd0);
        check_eq("rst_busy", 64'(bus.o_busy), 64'd0);
        check_eq("rst_data", bus.o_data, 64'd0);
        check_eq("rst_keep", 64'(bus.o_keep), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        restart_core();
        do_req(32, 0, "len32");
        restart_core();
        do_req(32, 1, "len32_bp");
        restart_core();
        do_req(12, 0, "len12");
        check_eq("len12_req_ready", 64'(bus.o_req_ready), 64'd1);
        // Continues on the next squeeze word: the tail of the partial word is gone.
        do_req(16, 0, "len16_next");
        do_req(21, 1, "len21");

        ack_cnt    = 0;
        bad_ready  = 0;
        seen_valid = 0;
        drive_req(0);
        for (int i = 0; i < 20; i++) begin
            if (!bus.o_req_ready) bad_ready++;
            if (bus.o_valid) seen_valid++;
            @(posedge clk);
            #1;
        end
        check_eq("len0_ready_drop", 64'(bad_ready), 64'd0);
        check_eq("len0_valid", 64'(seen_valid), 64'd0);
        check_eq("len0_acks", 64'(ack_cnt), 64'd0);

        restart_core();
        ready_mode  = 3;
        ready_limit = 1;
        beats_seen  = 0;
        exp_acks    = 0;
        push_req(32);
        drive_req(32);
        cyc = 0;
        while (beats_seen < 1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("rst_mid_reach", 64'(cyc < 200), 64'd1);
        repeat (2) @(posedge clk);
        #2;
        check_eq("emit_hi_stalled", bus.o_data, 64'hb3c3bb0b4a91f811);
        rst_n = 1'b0;
        #1;
        check_eq("arst_req_ready", 64'(bus.o_req_ready), 64'd1);
        check_eq("arst_valid", 64'(bus.o_valid), 64'd0);
        check_eq("arst_ack", 64'(bus.o_xof_ack), 64'd0);
        check_eq("arst_busy", 64'(bus.o_busy), 64'd0);
        check_eq("arst_last", 64'(bus.o_last), 64'd0);
        check_eq("arst_keep", 64'(bus.o_keep), 64'd0);
        check_eq("arst_data", bus.o_data, 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_pos = 0;
        do_req(16, 0, "post_rst_len16");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
